// File: rtl/mips_regfile_sb.sv
// Multi-read-port register file with write-to-read bypass and a pending-write scoreboard.
// Each read port resolves its own priority (reset, r0, bypass, stored) in a per-port instance.

module mips_regfile_rd_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  reset_n,
  input  logic                  clk_enable,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic                  reg_pend,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_index,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_busy
);
  always_comb begin
    read_data = reg_data;
    read_busy = reg_pend;
    if (!reset_n) begin
      read_data = '0;
      read_busy = 1'b0;
    end else if (ZERO_REG != 0 && index == '0) begin
      read_data = '0;
      read_busy = 1'b0;
    end else if (BYPASS != 0 && write_enable && clk_enable && write_index == index) begin
      read_data = write_data;
      read_busy = 1'b0;
    end
  end
endmodule

module mips_regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clk_enable,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_index,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            read_busy,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_index,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             issue_enable,
  input  logic [ADDR_WIDTH-1:0]            issue_index,
  output logic [DATA_WIDTH-1:0]            register_v0
);
  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0]      pending;

  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] rd_idx;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
  logic                                  wr_ok, iss_ok;

  // r0 is hardwired: it never stores a value nor becomes pending
  assign wr_ok  = write_enable && !(ZERO_REG != 0 && write_index == '0);
  assign iss_ok = issue_enable && !(ZERO_REG != 0 && issue_index == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pending <= '0;
    end else if (clk_enable) begin
      if (wr_ok) begin
        regs[write_index]    <= write_data;
        pending[write_index] <= 1'b0;
      end
      // issue after write so a fresh producer keeps the register pending
      if (iss_ok) pending[issue_index] <= 1'b1;
    end
  end

  assign rd_idx    = read_index;
  assign read_data = rd_data;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    mips_regfile_rd_port #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_port (
      .reset_n     (reset_n),
      .clk_enable  (clk_enable),
      .index       (rd_idx[p]),
      .reg_data    (regs[rd_idx[p]]),
      .reg_pend    (pending[rd_idx[p]]),
      .write_enable(write_enable),
      .write_index (write_index),
      .write_data  (write_data),
      .read_data   (rd_data[p]),
      .read_busy   (read_busy[p])
    );
  end

  assign register_v0 = reset_n ? regs[2] : '0;
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed bench for mips_regfile_sb; a second instance with BYPASS=0 shares all inputs.
`timescale 1ns/1ps
module tb_mips_regfile_sb;
  logic        clk = 1'b0;
  logic        reset_n, clk_enable;
  logic [9:0]  read_index;
  logic [63:0] rd_b, rd_n;
  logic [1:0]  busy_b, busy_n;
  logic        write_enable, issue_enable;
  logic [4:0]  write_index, issue_index;
  logic [31:0] write_data, v0_b, v0_n;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mips_regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .read_index(read_index),
    .read_data(rd_b), .read_busy(busy_b), .write_enable(write_enable),
    .write_index(write_index), .write_data(write_data), .issue_enable(issue_enable),
    .issue_index(issue_index), .register_v0(v0_b));

  mips_regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .read_index(read_index),
    .read_data(rd_n), .read_busy(busy_n), .write_enable(write_enable),
    .write_index(write_index), .write_data(write_data), .issue_enable(issue_enable),
    .issue_index(issue_index), .register_v0(v0_n));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    issue_enable = 1'b0;
  endtask

  task automatic wr(input logic [4:0] i, input logic [31:0] d);
    write_enable = 1'b1; write_index = i; write_data = d;
  endtask

  task automatic rd(input logic [4:0] i0, input logic [4:0] i1);
    read_index = {i1, i0};
    #1;
  endtask

  initial begin
    reset_n = 1'b0; clk_enable = 1'b1; read_index = '0;
    write_enable = 1'b0; write_index = '0; write_data = '0;
    issue_enable = 1'b0; issue_index = '0;
    tick();
    reset_n = 1'b1;

    // 1: state before reset, then reset clears it and overrides outputs
    wr(5, 32'hDEADBEEF); issue_enable = 1'b1; issue_index = 5'd6;
    tick(); idle();
    rd(5, 6);
    chk("pre_rst_r5", rd_b[31:0], 32'hDEADBEEF);
    chk("pre_rst_busy6", {31'd0, busy_b[1]}, 32'd1);
    reset_n = 1'b0; wr(2, 32'h0BADF00D);
    #1;
    chk("rst_ovr_data0", rd_b[31:0], 32'h0);
    chk("rst_ovr_busy", {30'd0, busy_b}, 32'h0);
    tick(); tick(); idle();
    chk("rst_v0", v0_b, 32'h0);
    reset_n = 1'b1;
    rd(5, 6);
    chk("post_rst_r5", rd_b[31:0], 32'h0);
    chk("post_rst_busy", {30'd0, busy_b}, 32'h0);
    chk("post_rst_v0", v0_b, 32'h0);

    // 2: write r2, read on both ports
    wr(2, 32'h12345678); tick(); idle();
    rd(2, 2);
    chk("r2_p0", rd_b[31:0], 32'h12345678);
    chk("r2_p1", rd_b[63:32], 32'h12345678);
    chk("r2_v0", v0_b, 32'h12345678);

    // 3: bypass vs. no-bypass on a same-cycle read
    wr(7, 32'h00000011); tick(); idle();
    wr(7, 32'hA5A5A5A5); rd(0, 7);
    chk("byp_p1", rd_b[63:32], 32'hA5A5A5A5);
    chk("nobyp_p1_old", rd_n[63:32], 32'h00000011);
    tick(); idle(); rd(0, 7);
    chk("nobyp_p1_new", rd_n[63:32], 32'hA5A5A5A5);

    // 4: scoreboard
    issue_enable = 1'b1; issue_index = 5'd9; tick(); idle();
    rd(9, 9);
    chk("sb_issue_busy", {31'd0, busy_b[0]}, 32'd1);
    wr(9, 32'h1); #1;
    chk("sb_byp_busy", {31'd0, busy_b[0]}, 32'd0);
    chk("sb_byp_data", rd_b[31:0], 32'h1);
    chk("sb_nobyp_busy", {31'd0, busy_n[0]}, 32'd1);
    tick(); idle(); #1;
    chk("sb_after_busy", {31'd0, busy_b[0]}, 32'd0);
    chk("sb_after_nb_busy", {31'd0, busy_n[0]}, 32'd0);
    wr(9, 32'h2); issue_enable = 1'b1; issue_index = 5'd9;
    tick(); idle(); #1;
    chk("sb_both_busy", {31'd0, busy_b[0]}, 32'd1);
    chk("sb_both_data", rd_n[31:0], 32'h2);
    issue_enable = 1'b1; tick(); idle();
    wr(9, 32'h3); tick(); idle(); #1;
    chk("sb_dbl_issue_clr", {31'd0, busy_b[0]}, 32'd0);

    // v0 is never bypassed
    wr(2, 32'h0000CAFE); rd(2, 0);
    chk("v0_nobyp", v0_b, 32'h12345678);
    chk("v0_port_byp", rd_b[31:0], 32'h0000CAFE);
    tick(); idle(); #1;
    chk("v0_new", v0_b, 32'h0000CAFE);

    // 5: r0 is hardwired
    wr(0, 32'hFFFFFFFF); issue_enable = 1'b1; issue_index = 5'd0; rd(0, 0);
    chk("r0_byp_p0", rd_b[31:0], 32'h0);
    chk("r0_byp_p1", rd_b[63:32], 32'h0);
    chk("r0_byp_busy", {30'd0, busy_b}, 32'h0);
    tick(); idle(); #1;
    chk("r0_data", rd_b[31:0], 32'h0);
    chk("r0_busy", {30'd0, busy_b}, 32'h0);

    // 6: stall freezes state and disables bypass
    clk_enable = 1'b0; wr(3, 32'h55); issue_enable = 1'b1; issue_index = 5'd4;
    rd(3, 4);
    chk("stall_nobyp", rd_b[31:0], 32'h0);
    tick(); #1;
    chk("stall_r3", rd_b[31:0], 32'h0);
    chk("stall_busy4", {31'd0, busy_b[1]}, 32'd0);
    clk_enable = 1'b1; #1;
    chk("unstall_byp", rd_b[31:0], 32'h55);
    tick(); idle(); #1;
    chk("unstall_r3", rd_b[31:0], 32'h55);
    chk("unstall_busy4", {31'd0, busy_b[1]}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
